// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Sibling buffers import this so they agree on default geometry.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 8;

  // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer-facing signal bundle of sync_fifo_flags.
// The slave modport is the FIFO itself; the master is whoever drives it.
interface sync_fifo_flags_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) ();

  localparam int CNT_W = clog2(DEPTH) + 1;

  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_en,
    output read_en,
    output data_in,
    input  data_out,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  write_en,
    input  read_en,
    input  data_in,
    output data_out,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/sync_fifo_flags_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset so the array can map onto distributed RAM.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_W    = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable watermarks,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_flags_if.slave  bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  logic                  full_q;
  logic                  empty_q;
  logic                  almost_full_q;
  logic                  almost_empty_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // A pop frees a slot this same edge, so a full FIFO still accepts a
  // concurrent write; a push never rescues a read from an empty FIFO.
  assign rd_acc = bus.read_en & ~empty_q;
  assign wr_acc = bus.write_en & (~full_q | rd_acc);

  always_comb begin
    count_next = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  // Flags are derived from the next count so they are registered yet
  // already describe the post-edge occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count_q        <= count_next;
      full_q         <= (count_next == CNT_W'(DEPTH));
      empty_q        <= (count_next == '0);
      almost_full_q  <= (count_next >= CNT_W'(AF_LEVEL));
      almost_empty_q <= (count_next <= CNT_W'(AE_LEVEL));
      overflow_q     <= bus.write_en & full_q & ~bus.read_en;
      underflow_q    <= bus.read_en & empty_q;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  if (FWFT == 0) begin : g_std_read
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        data_out_q <= '0;
      end else if (rd_acc) begin
        data_out_q <= ram_rd_data;
      end
    end

    assign bus.data_out = data_out_q;
  end else begin : g_fwft_read
    logic [DATA_WIDTH-1:0] last_popped_q;

    // While empty the port replays the last word handed out rather than stale RAM.
    always_ff @(posedge clk) begin
      if (reset) begin
        last_popped_q <= '0;
      end else if (rd_acc) begin
        last_popped_q <= ram_rd_data;
      end
    end

    assign bus.data_out = empty_q ? last_popped_q : ram_rd_data;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO, the next generation of the team's 16-bit x 8 synchronous FIFO.
- Generalises width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode.
- Sits between a producer and consumer stage in the same clock domain as a drop-in buffer.

Parameters:
DATA_WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), pointer/address width (derived, not overridden)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
write_en  in  1  write request
read_en  in  1  read request
data_in  in  DATA_WIDTH  write data, sampled on accepted write
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: rejected write
underflow  out  1  one-cycle pulse: rejected read

Behaviour:
- Reset, sampled at clk edge, dominates all other inputs. Values: wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, overflow=0, underflow=0. Memory contents are not cleared. Reset mid-operation discards all stored words.
- Write accept: wr_acc = write_en & (!full | rd_acc). On wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read accept: rd_acc = read_en & !empty. A write in the same cycle does not rescue a read on an empty FIFO. On rd_acc: rd_ptr increments with wrap.
- Count: count_next = count + wr_acc - rd_acc. Read+write both accepted leaves count unchanged, including when full.
- Flags: full, empty, almost_full, almost_empty and count are registered and reflect state after the edge. No combinational path from inputs to flags.
- overflow <= write_en & full & !read_en. Dropped data never alters memory or pointers.
- underflow <= read_en & empty.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr]; valid the cycle after the read edge (1-cycle latency).
  - data_out holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - data_out presents the head word whenever empty=0, with zero read latency. read_en acknowledges/pops it.
  - After a write into an empty FIFO, empty falls and data_out shows the word in the same following cycle.
  - When empty=1, data_out holds the last popped value (0 after reset).
- Pointer wrap: no bubble or extra cycle at the DEPTH-1 -> 0 boundary.

Decomposition:
- Shared package sync_fifo_pkg: a clog2 helper function and the default width/depth constants, reused by sibling buffers.
- One sub-module, fifo_ram: simple dual-port, DEPTH x DATA_WIDTH, synchronous write and asynchronous read. The top selects a registered or fall-through data_out around it.
- Pointer, count and flag logic stays in sync_fifo_flags.

Test Plan:
1. Fill (DEPTH=8, AF=6, AE=1, FWFT=0). Reset, then write 0..7 on consecutive cycles -> count 1..8; almost_empty drops when count=2; almost_full rises when count=6; full=1 after 8th write; empty=0 from the first.
2. Overflow. With FIFO full, write_en=1, read_en=0, data_in=16'hDEAD for 1 cycle -> overflow pulses 1 cycle; count stays 8; no 16'hDEAD in subsequent reads.
3. Drain and underflow. Read 8 times -> data_out 0..7, each one cycle after its read edge; empty=1 after the 8th read. A 9th read -> underflow pulse; data_out holds 7.
4. Simultaneous access and wrap. Do both of:
   - When full, read+write of 16'h00AA together -> count stays 8, full stays 1.
   - Run 20 interleaved write/read cycles -> pointers wrap; output order equals input order.
5. FWFT (FWFT=1). Write 16'h1234 to empty FIFO -> next cycle empty=0 and data_out=16'h1234 with no read. Read pops it -> empty=1.
6. Reset mid-operation. Reset asserted with count=5 and read_en=write_en=1 -> next cycle count=0, empty=1, data_out=0, overflow=underflow=0.
